tl_memory: RTL and testbench

TL_MEMORY -- requirements
Module: tl_memory

---
 rtl/tl_memory.sv | 158 +++++++++++++++
 tb/tb_tl_memory.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_memory.sv
// Memory-access pipeline stage: byte/half/word data RAM with sign/zero-extended loads,
// a one-cycle pass-through to writeback, and optional alignment checking (MEM_ALIGN_CHECK_EN).
module tl_memory #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 7,
    parameter int RAM_DEPTH            = 256
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic [LEN-1:0]                  i_alu_result,
    input  logic [LEN-1:0]                  i_dato2,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
    input  logic [$clog2(RAM_DEPTH)-1:0]    i_dbg_addr,
    output logic [LEN-1:0]                  o_dbg_data,
    output logic [LEN-1:0]                  o_read_data,
    output logic [LEN-1:0]                  o_alu_result,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
    output logic                            o_misaligned
);

    localparam int AW = $clog2(RAM_DEPTH);

    logic [LEN-1:0] r_ram [RAM_DEPTH];

    logic [LEN-1:0]                  r_read_data;
    logic [LEN-1:0]                  r_alu_result;
    logic [NB_ADDRESS_REGISTROS-1:0] r_write_reg;
    logic [NB_CTRL_WB-1:0]           r_ctrl_wb;

    logic           w_mem_write;
    logic           w_mem_read;
    logic           w_unsigned;
    logic [1:0]     w_size;
    logic           w_is_byte;
    logic           w_is_half;
    logic           w_is_word;
    logic [AW-1:0]  w_word_idx;
    logic [1:0]     w_lane;
    logic           w_misaligned;
    logic [LEN-1:0] w_old_word;
    logic [LEN-1:0] w_wmask;
    logic [LEN-1:0] w_wdata;
    logic [LEN-1:0] w_load_data;
    logic           w_unused;

    assign w_mem_write = i_ctrl_mem[6];
    assign w_mem_read  = i_ctrl_mem[5];
    assign w_unsigned  = i_ctrl_mem[4];
    assign w_size      = i_ctrl_mem[3:2];
    assign w_is_byte   = (w_size == 2'b00);
    assign w_is_half   = (w_size == 2'b01);
    // Size 2'b10 is not a defined encoding and behaves as a word access.
    assign w_is_word   = w_size[1];
    assign w_word_idx  = i_alu_result[AW+1:2];
    assign w_lane      = i_alu_result[1:0];
    assign w_unused    = ^{i_alu_result[LEN-1:AW+2], i_ctrl_mem[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = (w_mem_read | w_mem_write) &
                          ((w_is_half & w_lane[0]) | (w_is_word & (w_lane != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    // Extract the addressed byte/half from a RAM word and extend it to LEN bits.
    function automatic logic [LEN-1:0] load_extend(
        input logic [LEN-1:0] word,
        input logic [1:0]     lane,
        input logic           is_byte,
        input logic           is_half,
        input logic           uns
    );
        logic [LEN-1:0] sh;
        logic [7:0]     b;
        logic [15:0]    h;
        sh = '0;
        b  = '0;
        h  = '0;
        if (is_byte) begin
            sh = word >> {lane, 3'b000};
            b  = sh[7:0];
            load_extend = uns ? {{(LEN-8){1'b0}}, b} : {{(LEN-8){b[7]}}, b};
        end else if (is_half) begin
            sh = word >> {lane[1], 4'b0000};
            h  = sh[15:0];
            load_extend = uns ? {{(LEN-16){1'b0}}, h} : {{(LEN-16){h[15]}}, h};
        end else begin
            load_extend = word;
        end
    endfunction

    assign w_old_word  = r_ram[w_word_idx];
    assign w_load_data = load_extend(w_old_word, w_lane, w_is_byte, w_is_half, w_unsigned);
    assign o_dbg_data  = r_ram[i_dbg_addr];

    // Lane mask and replicated store data; the mask alone decides which bytes change.
    always_comb begin
        w_wmask = '1;
        w_wdata = i_dato2;
        if (w_is_byte) begin
            w_wmask = {{(LEN-8){1'b0}}, 8'hFF} << {w_lane, 3'b000};
            w_wdata = {(LEN/8){i_dato2[7:0]}};
        end else if (w_is_half) begin
            w_wmask = {{(LEN-16){1'b0}}, 16'hFFFF} << {w_lane[1], 4'b0000};
            w_wdata = {(LEN/16){i_dato2[15:0]}};
        end
    end

    // RAM is never cleared; writes are blocked while reset is held.
    always_ff @(negedge i_clk) begin
        if (i_rst && i_enable && w_mem_write && !w_misaligned) begin
            r_ram[w_word_idx] <= (w_old_word & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    // Stage boundary: memory -> writeback
    always_ff @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_write_reg  <= '0;
            r_ctrl_wb    <= '0;
        end else if (i_enable) begin
            r_read_data  <= (w_mem_read && !w_misaligned) ? w_load_data : '0;
            r_alu_result <= i_alu_result;
            r_write_reg  <= i_write_reg;
            r_ctrl_wb    <= i_ctrl_wb;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_misaligned <= 1'b0;
        end else if (i_enable && w_misaligned) begin
            r_misaligned <= 1'b1;
        end
    end

    assign o_misaligned = r_misaligned;
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_read_data  = r_read_data;
    assign o_alu_result = r_alu_result;
    assign o_write_reg  = r_write_reg;
    assign o_ctrl_wb    = r_ctrl_wb;

endmodule

// File: tb/tb_tl_memory.sv
// Scoreboard bench for tl_memory: directed loads/stores with hand-computed results,
// stall, async reset and alignment behaviour (follows MEM_ALIGN_CHECK_EN if defined).
module tb_tl_memory;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [31:0] alu = '0;
    logic [31:0] dato2 = '0;
    logic [4:0]  wreg = '0;
    logic [1:0]  cwb = '0;
    logic [6:0]  cmem = '0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [31:0] rd_data;
    logic [31:0] alu_out;
    logic [4:0]  wreg_out;
    logic [1:0]  cwb_out;
    logic        mis;

    always #5 clk = ~clk;

    tl_memory dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_enable     (en),
        .i_alu_result (alu),
        .i_dato2      (dato2),
        .i_write_reg  (wreg),
        .i_ctrl_wb    (cwb),
        .i_ctrl_mem   (cmem),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data   (dbg_data),
        .o_read_data  (rd_data),
        .o_alu_result (alu_out),
        .o_write_reg  (wreg_out),
        .o_ctrl_wb    (cwb_out),
        .o_misaligned (mis)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_vec = 0;
    int   n_err = 0;
    int   tag = 0;
    logic pend = 1'b0;
    logic exp_mis = 1'b0;

    // A falling edge with reset released and enable high produces one result.
    always @(negedge clk) pend <= rst_n && en;

    always @(posedge clk) begin
        if (pend) begin
            exp_t e;
            exp_t g;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got rd=%h alu=%h, want nothing pending", rd_data, alu_out);
            end else begin
                e = exp_q.pop_front();
                g = '{rd: rd_data, alu: alu_out, wr: wreg_out, wb: cwb_out, mis: mis};
                if (g !== e) begin
                    n_err++;
                    $display("FAIL result@%h: got rd=%h alu=%h wr=%0d wb=%0d mis=%b want rd=%h alu=%h wr=%0d wb=%0d mis=%b",
                             e.alu, g.rd, g.alu, g.wr, g.wb, g.mis, e.rd, e.alu, e.wr, e.wb, e.mis);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic op(input logic we, input logic re, input logic uns, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd_exp);
        exp_t e;
        @(posedge clk);
        #1;
        tag++;
        rst_n = 1'b1;
        en    = 1'b1;
        cmem  = {we, re, uns, sz, 2'b11};
        alu   = a;
        dato2 = d;
        wreg  = tag[4:0];
        cwb   = tag[1:0];
        if (ALIGN && (we || re) && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00)))
            exp_mis = 1'b1;
        e = '{rd: rd_exp, alu: a, wr: tag[4:0], wb: tag[1:0], mis: exp_mis};
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic chk_outputs_zero(input string tagname);
        chk({tagname, "_rd"},  rd_data, 32'h0);
        chk({tagname, "_alu"}, alu_out, 32'h0);
        chk({tagname, "_wr"},  {27'h0, wreg_out}, 32'h0);
        chk({tagname, "_wb"},  {30'h0, cwb_out}, 32'h0);
        chk({tagname, "_mis"}, {31'h0, mis}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("reset");
        #20;

        // word store then load, debug port view
        op(1, 0, 0, 2'b11, 32'h10, 32'hDEADBEEF, 32'h0);
        op(0, 1, 0, 2'b11, 32'h10, 32'h0, 32'hDEADBEEF);
        dbg_addr = 8'd4;
        #1 chk("dbg_word4", dbg_data, 32'hDEADBEEF);

        // byte store into a cleared word, signed/unsigned byte loads
        op(1, 0, 0, 2'b11, 32'h10, 32'h0, 32'h0);
        op(1, 0, 0, 2'b00, 32'h13, 32'h123456AA, 32'h0);
        op(0, 1, 0, 2'b00, 32'h13, 32'h0, 32'hFFFFFFAA);
        op(0, 1, 1, 2'b00, 32'h13, 32'h0, 32'h000000AA);
        op(0, 1, 0, 2'b11, 32'h10, 32'h0, 32'hAA000000);

        // half store into upper half, lower half kept
        op(1, 0, 0, 2'b11, 32'h20, 32'h00001234, 32'h0);
        op(1, 0, 0, 2'b01, 32'h22, 32'hFFFF8001, 32'h0);
        op(0, 1, 0, 2'b01, 32'h22, 32'h0, 32'hFFFF8001);
        op(0, 1, 1, 2'b01, 32'h22, 32'h0, 32'h00008001);
        op(0, 1, 0, 2'b11, 32'h20, 32'h0, 32'h80011234);
        op(0, 1, 0, 2'b00, 32'h20, 32'h0, 32'h00000034);
        op(0, 1, 0, 2'b00, 32'h21, 32'h0, 32'h00000012);
        op(0, 1, 1, 2'b00, 32'h23, 32'h0, 32'h00000080);
        op(0, 1, 0, 2'b00, 32'h23, 32'h0, 32'hFFFFFF80);

        // read and write together return the old word
        op(1, 1, 0, 2'b11, 32'h20, 32'h55667788, 32'h80011234);
        op(0, 1, 0, 2'b11, 32'h20, 32'h0, 32'h55667788);

        // stall: no write, outputs hold
        op(1, 0, 0, 2'b11, 32'h30, 32'h11111111, 32'h0);
        @(posedge clk);
        #1;
        en    = 1'b0;
        cmem  = 7'b1001111;
        alu   = 32'h30;
        dato2 = 32'h12345678;
        wreg  = 5'd31;
        cwb   = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        dbg_addr = 8'd12;
        #1;
        chk("stall_dbg12", dbg_data, 32'h11111111);
        chk("stall_rd",  rd_data, last_exp.rd);
        chk("stall_alu", alu_out, last_exp.alu);
        chk("stall_wr",  {27'h0, wreg_out}, {27'h0, last_exp.wr});
        chk("stall_wb",  {30'h0, cwb_out}, {30'h0, last_exp.wb});
        op(1, 0, 0, 2'b11, 32'h30, 32'h12345678, 32'h0);
        op(0, 1, 0, 2'b10, 32'h30, 32'h0, 32'h12345678);
        #1 chk("enabled_dbg12", dbg_data, 32'h12345678);

        // async reset between edges during a load
        op(0, 1, 0, 2'b11, 32'h30, 32'h0, 32'h12345678);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        dbg_addr = 8'd4;
        #1 chk("retained_dbg4", dbg_data, 32'hAA000000);
        dbg_addr = 8'd8;
        #1 chk("retained_dbg8", dbg_data, 32'h55667788);
        op(0, 1, 0, 2'b11, 32'h10, 32'h0, 32'hAA000000);

        // misaligned word store, misaligned loads
        op(1, 0, 0, 2'b11, 32'h40, 32'h00000000, 32'h0);
        op(1, 0, 0, 2'b11, 32'h41, 32'hCAFEF00D, 32'h0);
        op(0, 1, 0, 2'b11, 32'h40, 32'h0, ALIGN ? 32'h0 : 32'hCAFEF00D);
        op(0, 1, 0, 2'b11, 32'h41, 32'h0, ALIGN ? 32'h0 : 32'hCAFEF00D);
        op(0, 1, 0, 2'b01, 32'h23, 32'h0, ALIGN ? 32'h0 : 32'h00005566);
        dbg_addr = 8'd16;
        #1 chk("dbg_word16", dbg_data, ALIGN ? 32'h0 : 32'hCAFEF00D);

        @(posedge clk);
        #1 en = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("misaligned_flag", {31'h0, mis}, {31'h0, ALIGN});
        #2 rst_n = 1'b0;
        #1 chk("misaligned_after_reset", {31'h0, mis}, 32'h0);
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
